// File: rtl/goldseq_sched.sv
// goldseq_sched: arbitrates the DMRS hypothesis search and the PBCH descrambler onto the shared gold-sequence generator.
// Optional run watchdog is enabled by defining GOLDSEQ_TIMEOUT_EN (adds parameter TMO_CYC and port o_err_timeout).
module goldseq_sched #(
    parameter int MPN     = 288,
    parameter int NUM_HYP = 8
`ifdef GOLDSEQ_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 4095
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_ncellid,
    input  logic       i_ncellid_valid,
    input  logic       i_dmrs_req,
    output logic       o_dmrs_gnt,
    output logic       o_dmrs_done,
    input  logic       i_scr_req,
    input  logic [1:0] i_scr_issb,
    input  logic       i_scr_stall,
    output logic       o_scr_gnt,
    output logic       o_scr_done,
    output logic       o_gen_sel,
    output logic [9:0] o_gen_ncellid,
    output logic [1:0] o_gen_issb,
    output logic       o_gen_n_hf,
    output logic       o_gen_start,
    output logic       o_gen_flag,
    input  logic       i_gen_valid,
    input  logic       i_gen_done,
    output logic [2:0] o_hyp_idx,
    output logic [8:0] o_bit_cnt,
    output logic       o_cnt_err,
`ifdef GOLDSEQ_TIMEOUT_EN
    output logic       o_err_timeout,
`endif
    output logic       o_busy
);

    localparam logic [8:0] MPN_W    = 9'(MPN);
    localparam logic [2:0] HYP_LAST = 3'(NUM_HYP - 1);

    // IDLE wait | LOAD config | START pulse | RUN count bits | NEXT hypothesis step | DONE job end
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_NEXT, S_DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_cell_ok, r_last_scr, r_sel;
    logic [9:0] r_ncid_shadow;
    logic       w_go, w_pick_scr, w_more_hyp, w_load, w_sel_load, w_tmo;
    logic [2:0] w_hyp_load;
    logic [8:0] w_cnt_fin;

    assign w_go       = r_cell_ok && (i_dmrs_req || i_scr_req);
    assign w_pick_scr = i_scr_req && (!i_dmrs_req || !r_last_scr);
    assign w_more_hyp = !r_sel && (o_hyp_idx < HYP_LAST);
    assign w_load     = ((r_state == S_IDLE) && w_go) || ((r_state == S_NEXT) && w_more_hyp);
    assign w_sel_load = (r_state == S_IDLE) ? w_pick_scr : r_sel;
    assign w_hyp_load = (r_state == S_IDLE) ? 3'd0 : o_hyp_idx + 3'd1;
    // Final count includes a gen_valid arriving together with gen_done.
    assign w_cnt_fin  = (i_gen_valid && (o_bit_cnt != 9'h1FF)) ? o_bit_cnt + 9'd1 : o_bit_cnt;

`ifdef GOLDSEQ_TIMEOUT_EN
    localparam logic [11:0] TMO_M1 = 12'(TMO_CYC - 1);
    logic [11:0] r_wdog;
    assign w_tmo = (r_wdog == TMO_M1) && !i_gen_done;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_START;
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                if (i_gen_done) w_state_nxt = S_NEXT;
                else if (w_tmo) w_state_nxt = S_DONE;
            end
            S_NEXT:  w_state_nxt = w_more_hyp ? S_LOAD : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_gen_start = (r_state == S_START);
        o_gen_flag  = (r_state == S_RUN) && r_sel && !i_scr_stall && (o_bit_cnt < MPN_W);
        o_dmrs_done = (r_state == S_DONE) && !r_sel;
        o_scr_done  = (r_state == S_DONE) && r_sel;
        o_busy      = (r_state != S_IDLE);
        o_gen_sel   = r_sel;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cell_ok     <= 1'b0;
            r_last_scr    <= 1'b1;
            r_sel         <= 1'b0;
            r_ncid_shadow <= '0;
            o_gen_ncellid <= '0;
            o_gen_issb    <= '0;
            o_gen_n_hf    <= 1'b0;
            o_dmrs_gnt    <= 1'b0;
            o_scr_gnt     <= 1'b0;
            o_hyp_idx     <= '0;
            o_bit_cnt     <= '0;
            o_cnt_err     <= 1'b0;
`ifdef GOLDSEQ_TIMEOUT_EN
            o_err_timeout <= 1'b0;
            r_wdog        <= '0;
`endif
        end else begin
            if (i_ncellid_valid) begin
                r_ncid_shadow <= i_ncellid;
                r_cell_ok     <= 1'b1;
            end
            if (w_load) begin
                o_gen_ncellid <= r_ncid_shadow;
                o_gen_issb    <= w_sel_load ? i_scr_issb : w_hyp_load[1:0];
                o_gen_n_hf    <= w_sel_load ? 1'b0 : w_hyp_load[2];
                o_hyp_idx     <= w_hyp_load;
                o_bit_cnt     <= '0;
            end
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_sel      <= w_pick_scr;
                    o_dmrs_gnt <= !w_pick_scr;
                    o_scr_gnt  <= w_pick_scr;
                    o_cnt_err  <= 1'b0;
`ifdef GOLDSEQ_TIMEOUT_EN
                    o_err_timeout <= 1'b0;
`endif
                end
`ifdef GOLDSEQ_TIMEOUT_EN
                S_START: r_wdog <= '0;
`endif
                S_RUN: begin
                    if (i_gen_valid && (o_bit_cnt != 9'h1FF)) o_bit_cnt <= o_bit_cnt + 9'd1;
                    if (i_gen_done && (w_cnt_fin != MPN_W)) o_cnt_err <= 1'b1;
`ifdef GOLDSEQ_TIMEOUT_EN
                    r_wdog <= r_wdog + 12'd1;
                    if (w_tmo) o_err_timeout <= 1'b1;
`endif
                end
                S_DONE: begin
                    o_dmrs_gnt <= 1'b0;
                    o_scr_gnt  <= 1'b0;
                    r_last_scr <= r_sel;
                    o_hyp_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goldseq_sched.sv
// Scoreboard bench for goldseq_sched: random job mixes against a queue-based job/run model and a generator model.
// With GOLDSEQ_TIMEOUT_EN defined the DUT gets TMO_CYC=100 and every run is left to expire.
module tb_goldseq_sched;
    localparam int MPN = 288;
`ifdef GOLDSEQ_TIMEOUT_EN
    localparam int TMO = 100;
    logic err_timeout;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] ncellid = '0;
    logic ncellid_valid = 1'b0, dmrs_req = 1'b0, scr_req = 1'b0, scr_stall = 1'b0;
    logic [1:0] scr_issb = '0;
    logic gen_valid = 1'b0, gen_done = 1'b0;
    logic o_dmrs_gnt, o_dmrs_done, o_scr_gnt, o_scr_done, o_gen_sel, o_gen_n_hf;
    logic o_gen_start, o_gen_flag, o_cnt_err, o_busy;
    logic [9:0] o_gen_ncellid;
    logic [1:0] o_gen_issb;
    logic [2:0] o_hyp_idx;
    logic [8:0] o_bit_cnt;

    always #5 clk = ~clk;

    goldseq_sched #(
        .MPN(MPN), .NUM_HYP(8)
`ifdef GOLDSEQ_TIMEOUT_EN
        , .TMO_CYC(TMO)
`endif
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ncellid(ncellid), .i_ncellid_valid(ncellid_valid),
        .i_dmrs_req(dmrs_req), .o_dmrs_gnt(o_dmrs_gnt), .o_dmrs_done(o_dmrs_done),
        .i_scr_req(scr_req), .i_scr_issb(scr_issb), .i_scr_stall(scr_stall),
        .o_scr_gnt(o_scr_gnt), .o_scr_done(o_scr_done), .o_gen_sel(o_gen_sel),
        .o_gen_ncellid(o_gen_ncellid), .o_gen_issb(o_gen_issb), .o_gen_n_hf(o_gen_n_hf),
        .o_gen_start(o_gen_start), .o_gen_flag(o_gen_flag), .i_gen_valid(gen_valid),
        .i_gen_done(gen_done), .o_hyp_idx(o_hyp_idx), .o_bit_cnt(o_bit_cnt),
        .o_cnt_err(o_cnt_err),
`ifdef GOLDSEQ_TIMEOUT_EN
        .o_err_timeout(err_timeout),
`endif
        .o_busy(o_busy)
    );

    typedef struct {logic sel; logic [9:0] ncid; logic [1:0] issb; logic nhf; logic [2:0] hyp; logic err;} run_t;
    typedef struct {logic sel; logic err; logic tmo;} done_t;
    typedef struct {int bits; logic sel;} gen_t;

    run_t  q_run[$];
    done_t q_done[$];
    gen_t  q_gen[$];

    int checks = 0, failures = 0;
    int starts_seen = 0, done_seen = 0;
    logic model_last_scr = 1'b1;
    logic [9:0] model_ncid = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: pops run/done expectations when the DUT presents them
    always @(negedge clk) begin
        run_t r;
        done_t d;
        if (!rst) begin
            chk("gnt_exclusive", int'(o_dmrs_gnt & o_scr_gnt), 0);
            if (o_gen_start) begin
                starts_seen++;
                if (q_run.size() == 0) chk("start_unexpected", q_run.size(), 1);
                else begin
                    r = q_run.pop_front();
                    chk("start_sel", o_gen_sel, r.sel);
                    chk("start_ncellid", o_gen_ncellid, r.ncid);
                    chk("start_issb", o_gen_issb, r.issb);
                    chk("start_n_hf", o_gen_n_hf, r.nhf);
                    chk("start_hyp", o_hyp_idx, r.hyp);
                    chk("start_cnt_err", o_cnt_err, r.err);
                    chk("start_dmrs_gnt", o_dmrs_gnt, !r.sel);
                    chk("start_scr_gnt", o_scr_gnt, r.sel);
`ifdef GOLDSEQ_TIMEOUT_EN
                    chk("start_err_timeout", err_timeout, 0);
`endif
                end
            end
            if (o_dmrs_done || o_scr_done) begin
                done_seen++;
                chk("done_both", int'(o_dmrs_done & o_scr_done), 0);
                if (q_done.size() == 0) chk("done_unexpected", q_done.size(), 1);
                else begin
                    d = q_done.pop_front();
                    chk("done_who", o_scr_done, d.sel);
                    chk("done_cnt_err", o_cnt_err, d.err);
`ifdef GOLDSEQ_TIMEOUT_EN
                    chk("done_err_timeout", err_timeout, d.tmo);
`endif
                end
            end
        end
    end

    // ---------------- generator model: answers each gen_start, checks gen_flag / bit_cnt during runs
    logic g_pend = 1'b0, g_act = 1'b0, g_sel = 1'b0, exp_run;
    int g_tgt = 0, g_nv = 0, g_rc = 0, cyc = 0;
    always @(negedge clk) begin
        gen_t g;
        if (rst) begin
            g_pend = 1'b0; g_act = 1'b0;
            gen_valid = 1'b0; gen_done = 1'b0; scr_stall = 1'b0;
        end else begin
            cyc++;
            if (g_pend) begin
                g_pend = 1'b0; g_act = 1'b1; g_nv = 0; g_rc = 0;
                if (q_gen.size() == 0) begin
                    chk("gen_queue", q_gen.size(), 1);
                    g_tgt = MPN; g_sel = 1'b0;
                end else begin
                    g = q_gen.pop_front();
                    g_tgt = g.bits; g_sel = g.sel;
                end
            end
            if (g_act) g_rc++;
`ifdef GOLDSEQ_TIMEOUT_EN
            exp_run = g_act && !(g_tgt < 0 && g_rc > TMO);
`else
            exp_run = g_act;
`endif
            chk("gen_flag", o_gen_flag, int'(exp_run && g_sel && !scr_stall && g_nv < MPN));
            if (exp_run) chk("bit_cnt", o_bit_cnt, g_nv);
            gen_valid = 1'b0;
            gen_done  = 1'b0;
            if (g_act) begin
                if (g_tgt < 0) begin
`ifdef GOLDSEQ_TIMEOUT_EN
                    if (g_rc == TMO) chk("tmo_not_yet", err_timeout, 0);
                    if (g_rc == TMO + 1) begin
                        chk("tmo_flag", err_timeout, 1);
                        chk("tmo_done_pulse", int'(o_dmrs_done | o_scr_done), 1);
                        g_act = 1'b0;
                    end
`else
                    g_act = 1'b0;
`endif
                end else if (g_nv < g_tgt) begin
                    if ($urandom_range(7) != 0) begin
                        gen_valid = 1'b1;
                        g_nv++;
                        if (g_nv == g_tgt && $urandom_range(1) == 1) begin
                            gen_done = 1'b1; g_act = 1'b0;
                        end
                    end
                end else begin
                    gen_done = 1'b1; g_act = 1'b0;
                end
            end
            if (o_gen_start) g_pend = 1'b1;
            if (cyc % 3 == 0) scr_stall = !scr_stall;
        end
    end

    // ---------------- stimulus
    task automatic push_job(input logic is_scr, input logic [1:0] issb, input int mode);
        logic acc = 1'b0;
        int nruns = is_scr ? 1 : 8;
        int bits;
        logic [2:0] hv;
        run_t r;
        done_t d;
        gen_t g;
`ifdef GOLDSEQ_TIMEOUT_EN
        nruns = 1;
`endif
        for (int h = 0; h < nruns; h++) begin
            hv = 3'(h);
            bits = MPN;
            if (mode == 2 && is_scr) bits = 200;
            else if (mode == 0 && $urandom_range(9) == 0) bits = ($urandom_range(1) == 1) ? 200 : 290;
`ifdef GOLDSEQ_TIMEOUT_EN
            bits = -1;
`endif
            r.sel = is_scr; r.ncid = model_ncid;
            r.issb = is_scr ? issb : hv[1:0];
            r.nhf = is_scr ? 1'b0 : hv[2];
            r.hyp = is_scr ? 3'd0 : hv;
            r.err = acc;
            q_run.push_back(r);
            g.bits = bits; g.sel = is_scr;
            q_gen.push_back(g);
            if (bits >= 0 && bits != MPN) acc = 1'b1;
        end
        d.sel = is_scr; d.err = acc; d.tmo = (bits < 0);
        q_done.push_back(d);
        model_last_scr = is_scr;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_seen < target && t < 12000) begin
            @(negedge clk);
            t++;
        end
        chk("job_done_wait", done_seen, target);
    endtask

    task automatic do_round(input logic wd, input logic ws, input int mode, input int issb_in);
        logic [1:0] issb = (issb_in < 0) ? 2'($urandom_range(3)) : 2'(issb_in);
        logic first_scr = (wd && ws) ? !model_last_scr : ws;
        int n0 = done_seen;
        push_job(first_scr, issb, mode);
        if (wd && ws) push_job(!first_scr, issb, mode);
        @(negedge clk);
        scr_issb = issb;
        dmrs_req = wd;
        scr_req  = ws;
        wait_done(n0 + 1);
        if (first_scr) scr_req = 1'b0; else dmrs_req = 1'b0;
        if (wd && ws) begin
            wait_done(n0 + 2);
            if (first_scr) dmrs_req = 1'b0; else scr_req = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_run_queue", q_run.size(), 0);
    endtask

    task automatic load_ncid(input logic [9:0] v);
        @(negedge clk);
        ncellid = v;
        ncellid_valid = 1'b1;
        @(negedge clk);
        ncellid_valid = 1'b0;
        model_ncid = v;
    endtask

    function automatic int outs_ones();
        return $countones({o_dmrs_gnt, o_dmrs_done, o_scr_gnt, o_scr_done, o_gen_sel, o_gen_ncellid,
                           o_gen_issb, o_gen_n_hf, o_gen_start, o_gen_flag, o_hyp_idx, o_bit_cnt,
                           o_cnt_err, o_busy});
    endfunction

    initial begin
        int n0;
        int t;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", outs_ones(), 0);
        rst = 1'b0;
        dmrs_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_cellid_busy", o_busy, 0);
        chk("no_cellid_starts", starts_seen, 0);
        dmrs_req = 1'b0;
        load_ncid(10'h1F5);
`ifdef GOLDSEQ_TIMEOUT_EN
        do_round(1'b1, 1'b0, 1, -1);
        do_round(1'b0, 1'b1, 1, 2);
        do_round(1'b1, 1'b1, 1, -1);
`else
        do_round(1'b1, 1'b0, 1, -1);
        do_round(1'b1, 1'b1, 1, -1);
        do_round(1'b1, 1'b1, 0, -1);
        do_round(1'b0, 1'b1, 2, 2);
        do_round(1'b0, 1'b1, 1, 2);
        for (int k = 0; k < 3; k++) begin
            int p = $urandom_range(2);
            if ($urandom_range(1) == 1) load_ncid(10'($urandom_range(1007)));
            do_round(p != 1, p != 0, 0, -1);
        end
        // reset in the middle of hypothesis 4 of a DMRS job
        n0 = starts_seen;
        push_job(1'b0, 2'd0, 1);
        @(negedge clk);
        dmrs_req = 1'b1;
        t = 0;
        while (starts_seen < n0 + 5 && t < 12000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_hyp4", starts_seen, n0 + 5);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midjob_reset_zero", outs_ones(), 0);
        @(negedge clk);
        chk("midjob_reset_zero_hold", outs_ones(), 0);
        q_run.delete(); q_done.delete(); q_gen.delete();
        model_last_scr = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n0 = starts_seen;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", o_busy, 0);
        chk("post_reset_starts", starts_seen, n0);
        dmrs_req = 1'b0;
        load_ncid(10'($urandom_range(1007)));
        do_round(1'b1, 1'b1, 0, -1);
`endif
        repeat (5) @(negedge clk);
        chk("final_done_queue", q_done.size(), 0);
        chk("final_gen_queue", q_gen.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/goldseq_sched.md
Name: goldseq_sched

Overview:
Scheduler/controller for the shared gold-sequence generator in the postFFT chain.
- Arbitrates between two requesters: the DMRS hypothesis search and the PBCH descrambler.
- Loads generator configuration (cell ID, i_SSB, half-frame, sequence type) and pulses start.
- For DMRS, sweeps all 8 i_SSB/n_hf hypotheses back-to-back. For the scrambler, gates gen_flag with downstream backpressure.

Parameters:
MPN, 288, bits expected per generator run
NUM_HYP, 8, DMRS hypotheses per DMRS job (i_SSB 0..3 x n_hf 0..1)
TMO_CYC, 4095, watchdog limit in cycles per run (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ncellid  in  10  physical cell ID
ncellid_valid  in  1  pulse; latches ncellid
dmrs_req  in  1  DMRS job request (level)
dmrs_gnt  out  1  DMRS job granted/active
dmrs_done  out  1  1-cycle pulse, DMRS job finished
scr_req  in  1  scrambler job request (level)
scr_issb  in  2  i_SSB for scrambler job, sampled at grant
scr_stall  in  1  descrambler not ready; suppresses gen_flag
scr_gnt  out  1  scrambler job granted/active
scr_done  out  1  1-cycle pulse, scrambler job finished
gen_sel  out  1  0 = DMRS, 1 = scrambler
gen_ncellid  out  10  cell ID to generator
gen_issb  out  2  i_SSB to generator
gen_n_hf  out  1  half-frame bit to generator
gen_start  out  1  1-cycle pulse to generator (ncellid-ready pulse)
gen_flag  out  1  scrambler output enable
gen_valid  in  1  generator output bit valid
gen_done  in  1  generator finished run
hyp_idx  out  3  current DMRS hypothesis {n_hf, i_SSB}
bit_cnt  out  9  gen_valid count in current run
cnt_err  out  1  sticky: run ended with bit_cnt != MPN
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - Cell-ID-captured flag (cell_ok) cleared.
  - Round-robin pointer points at scrambler, so DMRS wins first.
- ncellid_valid latches ncellid into gen_ncellid and sets cell_ok. It is accepted in any state; a new value takes effect at the next LOAD.
- States: IDLE, LOAD, START, RUN, NEXT, DONE.
- IDLE -> LOAD when cell_ok and any request is present.
  - Both requests present: grant the one not served last.
  - Single request: grant it.
  - Grant asserts the cycle LOAD is entered and holds through DONE.
- LOAD (1 cycle):
  - Drive gen_sel.
  - DMRS: gen_issb = hyp_idx[1:0], gen_n_hf = hyp_idx[2].
  - Scrambler: gen_issb = latched scr_issb, gen_n_hf = 0.
  - Clear bit_cnt.
- START (1 cycle): gen_start = 1. Configuration outputs are stable from LOAD until leaving RUN.
- RUN:
  - bit_cnt increments on gen_valid and saturates at 511.
  - Scrambler: gen_flag = !scr_stall && bit_cnt < MPN. Always 0 for DMRS.
  - On gen_done -> NEXT. If bit_cnt (including a same-cycle gen_valid) != MPN, set cnt_err.
- NEXT:
  - DMRS with hyp_idx < NUM_HYP-1: increment hyp_idx and go to LOAD. Gap between runs is 3 cycles.
  - Otherwise -> DONE.
- DONE (1 cycle):
  - Pulse the matching *_done.
  - Drop the grant the next cycle.
  - Update the round-robin pointer and clear hyp_idx.
  - -> IDLE.
- Requests are sampled only in IDLE. Deasserting a request mid-job does not abort the job.
- cnt_err clears on the next grant.
- gen_done in IDLE or LOAD is ignored.
- Reset mid-job: immediate return to IDLE, all outputs 0, cell_ok cleared.

Optional Feature:
GOLDSEQ_TIMEOUT_EN
- Defined:
  - A 12-bit watchdog clears in START and counts every RUN cycle.
  - When it reaches TMO_CYC without gen_done, the FSM goes directly to DONE and asserts the sticky output err_timeout (cleared at next grant).
  - The remaining DMRS hypotheses are skipped; the requester's done still pulses.
- Undefined: no watchdog; the err_timeout port is absent; RUN waits indefinitely.

Test Plan:
1. ncellid=0x1F5 with ncellid_valid, then dmrs_req=1; model returns 288 gen_valid then gen_done per run -> 8 gen_start pulses, hyp_idx 0..7, gen_issb/gen_n_hf matching hyp_idx, one dmrs_done, cnt_err=0.
2. dmrs_req and scr_req asserted together, twice in a row -> first DMRS then scrambler; second round, scrambler is served after the DMRS job (the pointer alternates); never both grants high.
3. Scrambler job, scr_issb=2, scr_stall toggled every 3 cycles -> gen_flag=0 whenever stall=1; gen_flag drops when bit_cnt=288; gen_issb=2; scr_done pulses once.
4. Model issues gen_done after 200 bits -> cnt_err=1 and sequencing continues; next grant clears cnt_err.
5. rst asserted during hypothesis 4 of a DMRS job -> all outputs 0 next cycle; requests ignored until a new ncellid_valid.
6. GOLDSEQ_TIMEOUT_EN defined, TMO_CYC=100, model never sends gen_done -> err_timeout=1 at cycle 100 of RUN, then dmrs_done, then IDLE.
